// File: rtl/if_id_buffer.sv
// IF/ID pipeline register.
// Captures one 16-bit fetch word per cycle and merges two-word instructions
// (opcode word followed by a 16-bit immediate word) into a single decode
// bundle. While the immediate is outstanding, the register emits bubbles.
// Every output comes straight from a flop, so no input reaches an output
// without passing through a register.
module if_id_buffer #(
  parameter int IMM_BIT = 15,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            fetch_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [15:0]     instr_out,
  output logic [15:0]     imm_out,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] ret_addr,
  output logic            has_imm,
  output logic            valid_out,
  output logic            imm_pending
);

  // S_OP: waiting for an opcode word. S_IMM: opcode held, waiting for its immediate.
  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  state_e          state_q, state_d;

  logic [15:0]     instr_q, instr_d;
  logic [15:0]     imm_q, imm_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ret_q, ret_d;
  logic            has_imm_q, has_imm_d;
  logic            valid_q, valid_d;
  logic            imm_pending_q, imm_pending_d;

  // Opcode word and its address, parked while the immediate word is fetched.
  logic [15:0]     hold_op_q, hold_op_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;

  // A real word is consumed only when nothing higher-priority blocks the edge.
  logic            take_s;
  logic            is_two_word_s;

  assign take_s        = fetch_valid & ~flush & ~stall;
  assign is_two_word_s = instr_in[IMM_BIT];

  // Return-address helper: address of the word following an instruction of
  // the given length, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] next_addr(input logic [PC_W-1:0] base,
                                                input logic            two_word);
    logic [PC_W-1:0] len;
    if (two_word) begin
      len = PC_W'(2);
    end else begin
      len = PC_W'(1);
    end
    return base + len;
  endfunction

  // State register: flush/stall priority is resolved in the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush beats stall beats normal sequencing.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_OP;
    end else if (stall) begin
      state_d = state_q;
    end else if (!fetch_valid) begin
      // No word this cycle: a pending immediate simply keeps waiting.
      state_d = state_q;
    end else begin
      case (state_q)
        S_OP: begin
          if (is_two_word_s) begin
            state_d = S_IMM;
          end else begin
            state_d = S_OP;
          end
        end
        S_IMM: begin
          state_d = S_OP;
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end
  end

  // Output/datapath next values: build the decode bundle for the coming cycle.
  always_comb begin
    instr_d       = instr_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    ret_d         = ret_q;
    has_imm_d     = has_imm_q;
    valid_d       = valid_q;
    hold_op_d     = hold_op_q;
    hold_pc_d     = hold_pc_q;
    imm_pending_d = (state_d == S_IMM);

    if (flush) begin
      // Squash everything, including a half-assembled two-word instruction.
      instr_d   = 16'h0000;
      imm_d     = 16'h0000;
      pc_d      = '0;
      ret_d     = '0;
      has_imm_d = 1'b0;
      valid_d   = 1'b0;
      hold_op_d = 16'h0000;
      hold_pc_d = '0;
    end else if (stall) begin
      // Freeze: every register keeps its value.
      instr_d   = instr_q;
      imm_d     = imm_q;
    end else if (!fetch_valid) begin
      // Bubble; pc_out/ret_addr keep their last values.
      instr_d   = 16'h0000;
      imm_d     = 16'h0000;
      has_imm_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          if (is_two_word_s) begin
            // Park the opcode and emit a bubble until the immediate arrives.
            hold_op_d = instr_in;
            hold_pc_d = pc_in;
            instr_d   = 16'h0000;
            imm_d     = 16'h0000;
            has_imm_d = 1'b0;
            valid_d   = 1'b0;
          end else begin
            instr_d   = instr_in;
            imm_d     = 16'h0000;
            pc_d      = pc_in;
            ret_d     = next_addr(pc_in, 1'b0);
            has_imm_d = 1'b0;
            valid_d   = 1'b1;
          end
        end
        S_IMM: begin
          // The immediate word is taken verbatim; its top bit is not decoded.
          instr_d   = hold_op_q;
          imm_d     = instr_in;
          pc_d      = hold_pc_q;
          ret_d     = next_addr(hold_pc_q, 1'b1);
          has_imm_d = 1'b1;
          valid_d   = 1'b1;
        end
        default: begin
          instr_d   = 16'h0000;
          imm_d     = 16'h0000;
          has_imm_d = 1'b0;
          valid_d   = 1'b0;
        end
      endcase
    end
  end

  // Bundle, hold and pending registers; all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q       <= 16'h0000;
      imm_q         <= 16'h0000;
      pc_q          <= '0;
      ret_q         <= '0;
      has_imm_q     <= 1'b0;
      valid_q       <= 1'b0;
      imm_pending_q <= 1'b0;
      hold_op_q     <= 16'h0000;
      hold_pc_q     <= '0;
    end else begin
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      ret_q         <= ret_d;
      has_imm_q     <= has_imm_d;
      valid_q       <= valid_d;
      imm_pending_q <= imm_pending_d;
      hold_op_q     <= hold_op_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  assign instr_out   = instr_q;
  assign imm_out     = imm_q;
  assign pc_out      = pc_q;
  assign ret_addr    = ret_q;
  assign has_imm     = has_imm_q;
  assign valid_out   = valid_q;
  assign imm_pending = imm_pending_q;

  // take_s is a convenience decode kept for readability of the datapath intent.
  logic unused_s;
  assign unused_s = take_s;

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- IF/ID pipeline register directly downstream of the fetch stage; captures the 16-bit instruction word plus its 32-bit address every cycle.
- Merges two-word instructions (opcode word + 16-bit immediate word) into one decode bundle, inserting a bubble while the immediate is outstanding.
- Supports stall (hold) and flush (squash) from the control unit; produces the return address (pc + instruction length) used by CALL/INT.

Parameters:
- IMM_BIT, 15, bit of the opcode word that, when 1, marks a two-word instruction.
- PC_W, 32, width of pc_in/pc_out/ret_addr.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- instr_in  input  16  word from fetch stage (16'h0000 = NOP/bubble).
- pc_in  input  PC_W  address of instr_in, aligned in the same cycle.
- fetch_valid  input  1  instr_in/pc_in carry a real fetched word this cycle.
- stall  input  1  hold all registers and state.
- flush  input  1  squash contents and any partial two-word instruction.
- instr_out  output  16  opcode word to decode.
- imm_out  output  16  immediate word (0 for one-word instructions).
- pc_out  output  PC_W  address of the opcode word of instr_out.
- ret_addr  output  PC_W  pc_out + 1 (one-word) or pc_out + 2 (two-word), modulo 2^PC_W.
- has_imm  output  1  instr_out carries a valid imm_out.
- valid_out  output  1  bundle is a real instruction (0 = bubble).
- imm_pending  output  1  high while in S_IMM (control unit must not redirect PC without flushing).

Behaviour:
- Reset (async, immediate): state = S_OP; instr_out, imm_out, pc_out, ret_addr = 0; has_imm, valid_out, imm_pending = 0; hold registers = 0.
- imm_pending is a registered function of state: 1 exactly when state = S_IMM.
- Priority each edge: flush > stall > normal.
- flush: outputs take their reset values, state -> S_OP, held opcode/pc discarded. Applies even when stall is also high.
- stall (flush=0): every register and state unchanged; fetch word ignored. Fetch stage must hold or re-present the word.
- Normal, fetch_valid=0: outputs become a bubble (valid_out=0, instr_out=0, imm_out=0, has_imm=0, pc_out/ret_addr unchanged). State unchanged, so a pending immediate keeps waiting.
- Normal, fetch_valid=1, state S_OP:
  - instr_in[IMM_BIT]=0: instr_out=instr_in, imm_out=0, pc_out=pc_in, ret_addr=pc_in+1, has_imm=0, valid_out=1. Stay S_OP.
  - instr_in[IMM_BIT]=1: hold_op=instr_in, hold_pc=pc_in, output bubble (valid_out=0). Go S_IMM.
- Normal, fetch_valid=1, state S_IMM: instr_out=hold_op, imm_out=instr_in (taken verbatim, IMM_BIT not examined), pc_out=hold_pc, ret_addr=hold_pc+2, has_imm=1, valid_out=1. Go S_OP.
- Latency: one-word instruction appears one cycle after capture. Two-word instruction appears one cycle after its immediate word is captured, i.e. earliest two cycles after the opcode word.
- instr_in=16'h0000 with fetch_valid=1 is a legal NOP: valid_out=1, instr_out=0.
- ret_addr wraps: pc 32'hFFFF_FFFF one-word -> 0; two-word -> 1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle with state S_IMM -> all outputs 0 and imm_pending=0 immediately, without waiting for a clock edge. After release, word 16'h1234 @ pc 0x20 -> next cycle instr_out=16'h1234, pc_out=0x20, ret_addr=0x21, valid_out=1.
- Two-word: 16'h8005 @ 0x30, then 16'hBEEF @ 0x31 -> cycle 1: valid_out=0, imm_pending=1. Cycle 2: instr_out=16'h8005, imm_out=16'hBEEF, pc_out=0x30, ret_addr=0x32, has_imm=1.
- Stall: stall high for 3 cycles after 16'h8005 captured -> imm_pending stays 1, outputs frozen. Release and present 16'h00AA -> merged bundle with imm_out=16'h00AA.
- Flush in S_IMM with stall also high: -> outputs zero, state S_OP. Next word 16'h0101 -> treated as one-word opcode, valid_out=1, has_imm=0.
- Gap: fetch_valid low for 2 cycles between 16'h8001 and immediate 16'h0007 -> bubbles, imm_pending held 1, then merged bundle with imm_out=16'h0007.
- Wrap: one-word @ pc 0xFFFF_FFFF -> ret_addr=0. Two-word with opcode @ 0xFFFF_FFFF -> ret_addr=1.
